time_cnt_prog: RTL and testbench

//  Parametrised programmable time counter; next generation of the fixed 8-bit free-running counter.

---
 rtl/time_cnt_prog.sv | 154 +++++++++++++++
 tb/tb_time_cnt_prog.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_cnt_prog.sv
// time_cnt_prog: programmable time counter with prescaler, three count modes
// (wrap-up, one-shot-up, down-wrap), start/pause/clear control and a
// registered one-clock terminal-count tick.
module time_cnt_prog #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             pause,
    input  logic             clear,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] max_value,
    output logic [WIDTH-1:0] time_counter,
    output logic             tick,
    output logic             busy,
    output logic             done
);

    localparam int unsigned     PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0]   PRESC_ONE  = PW'(1);
    localparam logic [WIDTH-1:0] CNT_ONE   = WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Encoding 3 is accepted on the port and behaves exactly like WRAP.
    typedef enum logic [1:0] {
        M_WRAP     = 2'd0,
        M_ONESHOT  = 2'd1,
        M_DOWN     = 2'd2,
        M_WRAP_ALT = 2'd3
    } mode_t;

    state_t           state_q, state_d;
    mode_t            mode_q,  mode_d;
    logic [WIDTH-1:0] max_q,   max_d;
    logic [WIDTH-1:0] cnt_q,   cnt_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             tick_q,  tick_d;

    mode_t            mode_in;
    logic             idle_or_done;
    logic             step;
    logic [WIDTH-1:0] cnt_inc;
    logic [WIDTH-1:0] cnt_dec;

    // Decode helpers shared by the next-state logic.
    always_comb begin
        mode_in      = mode_t'(mode);
        idle_or_done = (state_q == S_IDLE) || (state_q == S_DONE);
        step         = (state_q == S_RUN) && (presc_q == PRESC_LAST);
        cnt_inc      = cnt_q + CNT_ONE;
        cnt_dec      = cnt_q - CNT_ONE;
    end

    // State, counter, prescaler and latched-configuration registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            mode_q  <= M_WRAP;
            max_q   <= '0;
            cnt_q   <= '0;
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            max_q   <= max_d;
            cnt_q   <= cnt_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
        end
    end

    // Next-state logic: clear beats pause, pause (only meaningful in RUN) beats start.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        max_d   = max_q;
        cnt_d   = cnt_q;
        presc_d = presc_q;
        tick_d  = 1'b0;

        if (clear) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            presc_d = '0;
        end else if (pause && (state_q == S_RUN)) begin
            state_d = S_PAUSE;
        end else if (start && idle_or_done) begin
            mode_d  = mode_in;
            max_d   = max_value;
            presc_d = '0;
            if ((mode_in == M_ONESHOT) && (max_value == '0)) begin
                // Zero-length one-shot: terminal immediately, no RUN phase.
                state_d = S_DONE;
                cnt_d   = '0;
                tick_d  = 1'b1;
            end else begin
                state_d = S_RUN;
                cnt_d   = (mode_in == M_DOWN) ? max_value : '0;
            end
        end else if (start && (state_q == S_PAUSE)) begin
            state_d = S_RUN;
        end else if (state_q == S_RUN) begin
            if (step) begin
                presc_d = '0;
                unique case (mode_q)
                    M_ONESHOT: begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == max_q) begin
                            state_d = S_DONE;
                            tick_d  = 1'b1;
                        end
                    end
                    M_DOWN: begin
                        if (cnt_q == '0) begin
                            cnt_d  = max_q;
                            tick_d = 1'b1;
                        end else begin
                            cnt_d = cnt_dec;
                        end
                    end
                    default: begin
                        if (cnt_q == max_q) begin
                            cnt_d  = '0;
                            tick_d = 1'b1;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                endcase
            end else begin
                presc_d = presc_q + PRESC_ONE;
            end
        end
    end

    // Outputs come straight from registers; no input-to-output path.
    always_comb begin
        time_counter = cnt_q;
        tick         = tick_q;
        busy         = (state_q == S_RUN);
        done         = (state_q == S_DONE);
    end

endmodule

// File: tb/tb_time_cnt_prog.sv
// Bench for time_cnt_prog: three instances (PRESCALE 1, 3, 4) share one
// stimulus stream and are checked every cycle against a model that derives
// the count from the number of RUN clocks elapsed since the last start.
module tb_time_cnt_prog;

    localparam int NI = 3;

    typedef enum int {MS_IDLE, MS_RUN, MS_PAUSE, MS_DONE} mst_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       clear = 1'b0;
    logic [1:0] mode  = 2'd0;
    logic [7:0] max_value = 8'd0;

    logic [7:0] cnt0, cnt1, cnt2;
    logic       tick0, tick1, tick2;
    logic       busy0, busy1, busy2;
    logic       done0, done1, done2;

    time_cnt_prog #(.WIDTH(8), .PRESCALE(1)) u0 (
        .clock(clock), .reset(reset), .start(start), .pause(pause), .clear(clear),
        .mode(mode), .max_value(max_value),
        .time_counter(cnt0), .tick(tick0), .busy(busy0), .done(done0)
    );
    time_cnt_prog #(.WIDTH(8), .PRESCALE(3)) u1 (
        .clock(clock), .reset(reset), .start(start), .pause(pause), .clear(clear),
        .mode(mode), .max_value(max_value),
        .time_counter(cnt1), .tick(tick1), .busy(busy1), .done(done1)
    );
    time_cnt_prog #(.WIDTH(8), .PRESCALE(4)) u2 (
        .clock(clock), .reset(reset), .start(start), .pause(pause), .clear(clear),
        .mode(mode), .max_value(max_value),
        .time_counter(cnt2), .tick(tick2), .busy(busy2), .done(done2)
    );

    initial forever #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state per instance.
    mst_t        m_state [NI];
    int unsigned m_run   [NI];
    int unsigned m_mode  [NI];
    int unsigned m_max   [NI];
    bit          m_tick  [NI];

    function automatic int unsigned psc(input int i);
        case (i)
            0:       return 1;
            1:       return 3;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] dut_cnt(input int i);
        case (i)
            0:       return {24'd0, cnt0};
            1:       return {24'd0, cnt1};
            default: return {24'd0, cnt2};
        endcase
    endfunction

    function automatic logic [31:0] dut_tick(input int i);
        case (i)
            0:       return {31'd0, tick0};
            1:       return {31'd0, tick1};
            default: return {31'd0, tick2};
        endcase
    endfunction

    function automatic logic [31:0] dut_busy(input int i);
        case (i)
            0:       return {31'd0, busy0};
            1:       return {31'd0, busy1};
            default: return {31'd0, busy2};
        endcase
    endfunction

    function automatic logic [31:0] dut_done(input int i);
        case (i)
            0:       return {31'd0, done0};
            1:       return {31'd0, done1};
            default: return {31'd0, done2};
        endcase
    endfunction

    // Count follows from steps taken = RUN clocks / PRESCALE.
    function automatic logic [31:0] exp_cnt(input int i);
        int unsigned steps;
        int unsigned per;
        steps = m_run[i] / psc(i);
        per   = m_max[i] + 1;
        case (m_state[i])
            MS_IDLE: return 32'd0;
            MS_DONE: return m_max[i];
            default: begin
                case (m_mode[i])
                    1:       return steps;
                    2:       return m_max[i] - (steps % per);
                    default: return steps % per;
                endcase
            end
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        int unsigned steps;
        for (int i = 0; i < NI; i++) begin
            m_tick[i] = 1'b0;
            if (reset) begin
                m_state[i] = MS_IDLE;
                m_run[i]   = 0;
                m_mode[i]  = 0;
                m_max[i]   = 0;
            end else if (clear) begin
                m_state[i] = MS_IDLE;
                m_run[i]   = 0;
            end else if (pause && m_state[i] == MS_RUN) begin
                m_state[i] = MS_PAUSE;
            end else if (start && (m_state[i] == MS_IDLE || m_state[i] == MS_DONE)) begin
                m_mode[i] = (mode == 2'd3) ? 0 : int'(mode);
                m_max[i]  = max_value;
                m_run[i]  = 0;
                if (m_mode[i] == 1 && m_max[i] == 0) begin
                    m_state[i] = MS_DONE;
                    m_tick[i]  = 1'b1;
                end else begin
                    m_state[i] = MS_RUN;
                end
            end else if (start && m_state[i] == MS_PAUSE) begin
                m_state[i] = MS_RUN;
            end else if (m_state[i] == MS_RUN) begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] % psc(i) == 0) begin
                    steps = m_run[i] / psc(i);
                    if (m_mode[i] == 1) begin
                        if (steps == m_max[i]) begin
                            m_state[i] = MS_DONE;
                            m_tick[i]  = 1'b1;
                        end
                    end else if (steps % (m_max[i] + 1) == 0) begin
                        m_tick[i] = 1'b1;
                    end
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            m_state[i] = MS_IDLE;
            m_run[i]   = 0;
            m_mode[i]  = 0;
            m_max[i]   = 0;
            m_tick[i]  = 1'b0;
        end
        forever begin
            @(posedge clock or posedge reset);
            model_update();
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clock);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("cnt[%0d]", i),  dut_cnt(i),  exp_cnt(i));
            chk($sformatf("tick[%0d]", i), dut_tick(i), {31'd0, m_tick[i]});
            chk($sformatf("busy[%0d]", i), dut_busy(i), {31'd0, m_state[i] == MS_RUN});
            chk($sformatf("done[%0d]", i), dut_done(i), {31'd0, m_state[i] == MS_DONE});
        end
    end

    task automatic step_n(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_start(input int md, input int mx);
        mode      = 2'(md);
        max_value = 8'(mx);
        start     = 1'b1;
        @(negedge clock);
        start     = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
    endtask

    initial begin
        int r;
        #1 reset = 1'b1;
        step_n(1);
        chk("reset_cnt0",  {24'd0, cnt0}, 32'd0);
        chk("reset_busy0", {31'd0, busy0}, 32'd0);
        chk("reset_done2", {31'd0, done2}, 32'd0);
        reset = 1'b0;
        step_n(1);

        // WRAP M=9, P=1: period 10, tick with every 0.
        do_start(0, 9);
        chk("wrap_first", {24'd0, cnt0}, 32'd0);
        step_n(9);
        chk("wrap_9",     {24'd0, cnt0}, 32'd9);
        chk("wrap_notick", {31'd0, tick0}, 32'd0);
        step_n(1);
        chk("wrap_0",     {24'd0, cnt0}, 32'd0);
        chk("wrap_tick",  {31'd0, tick0}, 32'd1);
        step_n(10);
        chk("wrap_tick2", {31'd0, tick0}, 32'd1);
        do_clear();

        // ONESHOT M=3, P=4: reaches 3 twelve clocks after start.
        do_start(1, 3);
        step_n(11);
        chk("os_cnt11",  {24'd0, cnt2}, 32'd2);
        chk("os_done11", {31'd0, done2}, 32'd0);
        step_n(1);
        chk("os_cnt12",  {24'd0, cnt2}, 32'd3);
        chk("os_done12", {31'd0, done2}, 32'd1);
        chk("os_tick12", {31'd0, tick2}, 32'd1);
        step_n(10);
        chk("os_hold",   {24'd0, cnt2}, 32'd3);
        chk("os_tick_once", {31'd0, tick2}, 32'd0);
        do_clear();

        // DOWN M=5, P=1: 5,4,..,0,5 with tick on reload.
        do_start(2, 5);
        chk("down_first", {24'd0, cnt0}, 32'd5);
        step_n(1);
        chk("down_4",     {24'd0, cnt0}, 32'd4);
        step_n(4);
        chk("down_0",     {24'd0, cnt0}, 32'd0);
        step_n(1);
        chk("down_reload", {24'd0, cnt0}, 32'd5);
        chk("down_tick",   {31'd0, tick0}, 32'd1);
        do_clear();

        // WRAP P=3: pause at 4, hold, resume finishes remaining phase.
        do_start(0, 9);
        step_n(13);
        chk("p3_cnt4", {24'd0, cnt1}, 32'd4);
        pause = 1'b1;
        @(negedge clock);
        pause = 1'b0;
        step_n(20);
        chk("pause_cnt",  {24'd0, cnt1}, 32'd4);
        chk("pause_busy", {31'd0, busy1}, 32'd0);
        do_start(3, 200);
        chk("resume_cnt",  {24'd0, cnt1}, 32'd4);
        chk("resume_busy", {31'd0, busy1}, 32'd1);
        step_n(2);
        chk("resume_5", {24'd0, cnt1}, 32'd5);
        start = 1'b1;
        pause = 1'b1;
        @(negedge clock);
        start = 1'b0;
        pause = 1'b0;
        chk("sp_busy", {31'd0, busy1}, 32'd0);
        do_clear();
        chk("clr_cnt", {24'd0, cnt1}, 32'd0);

        // Async reset between edges mid-RUN.
        do_start(0, 9);
        step_n(4);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        chk("areset_cnt0", {24'd0, cnt0}, 32'd0);
        chk("areset_busy", {31'd0, busy0}, 32'd0);
        chk("areset_cnt2", {24'd0, cnt2}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        do_start(0, 9);
        step_n(3);
        chk("restart_cnt", {24'd0, cnt0}, 32'd3);

        // Edges: full-range wrap and zero-length one-shot.
        do_clear();
        do_start(0, 255);
        step_n(255);
        chk("w255_cnt", {24'd0, cnt0}, 32'd255);
        step_n(1);
        chk("w255_wrap", {24'd0, cnt0}, 32'd0);
        chk("w255_tick", {31'd0, tick0}, 32'd1);
        do_clear();
        do_start(1, 0);
        chk("os0_done", {31'd0, done0}, 32'd1);
        chk("os0_tick", {31'd0, tick0}, 32'd1);
        step_n(1);
        chk("os0_tick_off", {31'd0, tick0}, 32'd0);

        // Randomized control traffic (start and pause never together here).
        do_clear();
        for (int c = 0; c < 3000; c++) begin
            r         = $urandom_range(0, 99);
            clear     = (r < 2);
            pause     = (r >= 2 && r < 8);
            start     = (r >= 8 && r < 20);
            mode      = 2'($urandom_range(0, 3));
            max_value = ($urandom_range(0, 9) < 7) ? 8'($urandom_range(0, 12))
                                                   : 8'($urandom_range(0, 255));
            @(negedge clock);
        end
        clear = 1'b0;
        pause = 1'b0;
        start = 1'b0;
        step_n(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
